// File: rtl/segment_reader.sv
// Recovers hex digits from a multiplexed 7-segment display bus.
// A digit is captured once its pattern has been stable for STABLE_CYCLES edges.
module segment_reader #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [8:0]  seg,
    input  logic [3:0]  dig_en,
    output logic [15:0] hex,
    output logic [3:0]  dp_out,
    output logic [3:0]  valid,
    output logic [3:0]  err,
    output logic        capture,
    output logic        frame_done
);

    localparam logic [7:0] SAT  = 8'(STABLE_CYCLES);
    localparam logic [7:0] LAST = 8'(STABLE_CYCLES - 1);

    logic [8:0] stage_seg;
    logic [3:0] stage_en;
    logic [7:0] cnt;
    logic [3:0] seen;

    logic       onehot;
    logic       changed;
    logic       fire;
    logic [1:0] idx;
    logic       known;
    logic       blank;
    logic [3:0] val;
    logic [3:0] seen_nxt;

    always_comb begin
        onehot  = (dig_en != 4'd0) && ((dig_en & (dig_en - 4'd1)) == 4'd0);
        changed = (seg != stage_seg) || (dig_en != stage_en) || !onehot;
        fire    = !changed && (cnt == LAST);
        // Only meaningful when dig_en is one-hot, which fire guarantees.
        idx      = {dig_en[3] | dig_en[2], dig_en[3] | dig_en[1]};
        seen_nxt = seen | dig_en;
        blank    = (seg[7:0] == 8'h00);
    end

    always_comb begin
        known = 1'b1;
        val   = 4'h0;
        unique case (seg[7:0])
            8'h3F: val = 4'h0;
            8'h06: val = 4'h1;
            8'hDB: val = 4'h2;
            8'h4F: val = 4'h3;
            8'hE6: val = 4'h4;
            8'hED: val = 4'h5;
            8'hFD: val = 4'h6;
            8'h07: val = 4'h7;
            8'hFF: val = 4'h8;
            8'hEF: val = 4'h9;
            8'hF7: val = 4'hA;
            8'hFC: val = 4'hB;
            8'h39: val = 4'hC;
            8'hDE: val = 4'hD;
            8'hB9: val = 4'hE;
            8'hB1: val = 4'hF;
            default: known = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_seg  <= '0;
            stage_en   <= '0;
            cnt        <= '0;
            seen       <= '0;
            hex        <= '0;
            dp_out     <= '0;
            valid      <= '0;
            err        <= '0;
            capture    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            stage_seg  <= seg;
            stage_en   <= dig_en;
            capture    <= 1'b0;
            frame_done <= 1'b0;
            if (changed)
                cnt <= '0;
            else if (cnt != SAT)
                cnt <= cnt + 8'd1;
            if (fire) begin
                capture     <= 1'b1;
                dp_out[idx] <= seg[8];
                if (known) begin
                    hex[idx*4 +: 4] <= val;
                    valid[idx]      <= 1'b1;
                    err[idx]        <= 1'b0;
                end else begin
                    valid[idx] <= 1'b0;
                    err[idx]   <= !blank;
                end
                if (seen_nxt == 4'hF) begin
                    frame_done <= 1'b1;
                    seen       <= '0;
                end else begin
                    seen <= seen_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_segment_reader.sv
// Directed checks of segment_reader capture timing, decode and frame tracking.
module tb_segment_reader;

    logic        clk;
    logic        rst;
    logic [8:0]  seg;
    logic [3:0]  dig_en;
    logic [15:0] hex;
    logic [3:0]  dp_out;
    logic [3:0]  valid;
    logic [3:0]  err;
    logic        capture;
    logic        frame_done;

    int checks;
    int errors;
    int caps;
    int fds;
    int both;

    segment_reader #(.STABLE_CYCLES(4)) dut (
        .clk(clk),
        .rst(rst),
        .seg(seg),
        .dig_en(dig_en),
        .hex(hex),
        .dp_out(dp_out),
        .valid(valid),
        .err(err),
        .capture(capture),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive inputs and count pulses over n edges, sampling 1 after each edge.
    task automatic hold(input logic [3:0] en, input logic [8:0] s,
                        input int n);
        dig_en = en;
        seg    = s;
        caps   = 0;
        fds    = 0;
        both   = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (capture) caps++;
            if (frame_done) fds++;
            if (capture && frame_done) both++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        seg    = '0;
        dig_en = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hex", 32'(hex), 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_dp", 32'(dp_out), 32'h0);
        chk("rst_cap", 32'(capture), 32'h0);
        chk("rst_fd", 32'(frame_done), 32'h0);
        rst = 1'b0;

        // Single digit: capture exactly at E4, not before, one pulse.
        hold(4'b0001, 9'h006, 4);
        chk("d1_early", 32'(caps), 32'd0);
        hold(4'b0001, 9'h006, 1);
        chk("d1_cap", 32'(caps), 32'd1);
        chk("d1_hex", 32'(hex[3:0]), 32'h1);
        chk("d1_valid", 32'(valid), 32'h1);
        hold(4'b0001, 9'h006, 3);
        chk("d1_sat", 32'(caps), 32'd0);

        // Short F7 window never captures; FC window does.
        hold(4'b0100, 9'h1F7, 3);
        chk("f7_nocap", 32'(caps), 32'd0);
        hold(4'b0100, 9'h1FC, 5);
        chk("fc_cap", 32'(caps), 32'd1);
        chk("fc_hex", 32'(hex[11:8]), 32'hB);
        chk("fc_dp", 32'(dp_out[2]), 32'h1);

        // dig_en change with seg unchanged restarts the window.
        hold(4'b0001, 9'h006, 3);
        hold(4'b0010, 9'h006, 4);
        chk("en_restart", 32'(caps), 32'd0);
        hold(4'b0010, 9'h006, 1);
        chk("en_cap", 32'(caps), 32'd1);
        chk("en_hex", 32'(hex[7:4]), 32'h1);

        // Full frame from a clean seen mask.
        do_reset();
        hold(4'b0001, 9'h03F, 6);
        chk("fr0_cap", 32'(caps), 32'd1);
        chk("fr0_fd", 32'(fds), 32'd0);
        hold(4'b0010, 9'h04F, 6);
        chk("fr1_cap", 32'(caps), 32'd1);
        chk("fr1_fd", 32'(fds), 32'd0);
        hold(4'b0100, 9'h0DB, 6);
        chk("fr2_cap", 32'(caps), 32'd1);
        chk("fr2_fd", 32'(fds), 32'd0);
        hold(4'b1000, 9'h0B1, 6);
        chk("fr3_cap", 32'(caps), 32'd1);
        chk("fr3_fd_same", 32'(both), 32'd1);
        chk("fr3_fd", 32'(fds), 32'd1);
        chk("fr_hex", 32'(hex), 32'hF230);
        chk("fr_valid", 32'(valid), 32'hF);
        chk("fr_seen", 32'(dut.seen), 32'h0);

        // Re-capturing a seen digit does not complete a frame.
        hold(4'b0001, 9'h03F, 6);
        chk("rc_seen", 32'(dut.seen), 32'h1);
        hold(4'b0001, 9'h0FF, 6);
        chk("rc_hex", 32'(hex[3:0]), 32'h8);
        chk("rc_seen2", 32'(dut.seen), 32'h1);
        chk("rc_fd", 32'(fds), 32'd0);

        // Multi-hot never captures; then unrecognised code flags err.
        hold(4'b0011, 9'h006, 10);
        chk("mh_nocap", 32'(caps), 32'd0);
        chk("mh_hex", 32'(hex), 32'hF238);
        hold(4'b0010, 9'h055, 5);
        chk("bad_cap", 32'(caps), 32'd1);
        chk("bad_err", 32'(err), 32'h2);
        chk("bad_valid", 32'(valid), 32'hD);
        chk("bad_hex", 32'(hex[7:4]), 32'h3);

        // Blank: valid and err clear, digit kept, dp still loads.
        hold(4'b0001, 9'h100, 5);
        chk("blk_valid", 32'(valid), 32'hC);
        chk("blk_err", 32'(err), 32'h2);
        chk("blk_hex", 32'(hex[3:0]), 32'h8);
        chk("blk_dp", 32'(dp_out[0]), 32'h1);

        // Reset mid-window aborts it; a full window follows release.
        hold(4'b0001, 9'h0ED, 3);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_hex", 32'(hex), 32'h0);
        chk("ar_valid", 32'(valid), 32'h0);
        chk("ar_err", 32'(err), 32'h0);
        chk("ar_dp", 32'(dp_out), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        hold(4'b0001, 9'h0ED, 4);
        chk("ar_early", 32'(caps), 32'd0);
        hold(4'b0001, 9'h0ED, 1);
        chk("ar_cap", 32'(caps), 32'd1);
        chk("ar_hex5", 32'(hex[3:0]), 32'h5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
